// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - frames a sample stream into a 64-point FFT core and drains its results in bin order
// Optional watchdog on the core's BUSY phase: define FFT_SEQ_WATCHDOG_EN.
module fft_sequencer #(
    parameter int N       = 64,
    parameter int W       = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_re,
    input  logic [W-1:0]        in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_re,
    output logic [W-1:0]        out_im,
    output logic [5:0]          out_index,
    output logic                out_last,
    output logic                fft_start,
    input  logic                fft_done,
    output logic [N-1:0][W-1:0] fft_in_re,
    output logic [N-1:0][W-1:0] fft_in_im,
    input  logic [N-1:0][W-1:0] fft_out_re,
    input  logic [N-1:0][W-1:0] fft_out_im,
    output logic                busy,
    output logic [7:0]          frame_cnt,
    output logic                err_timeout
);

    localparam logic [5:0] IDX_MAX = 6'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [N-1:0][W-1:0] frame_re;
    logic [N-1:0][W-1:0] frame_im;
    logic [5:0]          wr_cnt;
    logic [5:0]          rd_idx;
    logic                buf_full;
    logic                accept;
    logic                drain_hs;
    logic                wd_expire;

    assign in_ready  = ~buf_full;
    assign accept    = in_valid & in_ready;
    assign drain_hs  = out_valid & out_ready;
    assign fft_in_re = frame_re;
    assign fft_in_im = frame_im;

    // Registers move on the falling edge so they line up with the FFT core.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        fft_start = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (buf_full) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                fft_start = 1'b1;
                state_n   = S_BUSY;
            end
            S_BUSY: begin
                if (fft_done) begin
                    state_n = S_DRAIN;
                end else if (wd_expire) begin
                    state_n = S_IDLE;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (rd_idx == IDX_MAX)) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                busy    = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign out_index = rd_idx;
    assign out_last  = out_valid && (rd_idx == IDX_MAX);
    assign out_re    = out_valid ? fft_out_re[rd_idx] : '0;
    assign out_im    = out_valid ? fft_out_im[rd_idx] : '0;

    // The next frame may fill while the core works; START is the only clear of buf_full.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            frame_re  <= '0;
            frame_im  <= '0;
            wr_cnt    <= '0;
            buf_full  <= 1'b0;
            rd_idx    <= '0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                frame_re[wr_cnt] <= in_re;
                frame_im[wr_cnt] <= in_im;
                if (wr_cnt == IDX_MAX) begin
                    wr_cnt   <= '0;
                    buf_full <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 6'd1;
                end
            end
            if (fft_start) begin
                buf_full <= 1'b0;
            end
            if (drain_hs) begin
                if (rd_idx == IDX_MAX) begin
                    rd_idx    <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    rd_idx <= rd_idx + 6'd1;
                end
            end
        end
    end

`ifdef FFT_SEQ_WATCHDOG_EN
    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] wd_cnt;
    logic           err_q;

    // A done arriving on the final BUSY cycle still wins over the abort.
    assign wd_expire   = (state == S_BUSY) && !fft_done && (wd_cnt == WD_LAST);
    assign err_timeout = err_q;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wd_expire;
            if ((state == S_BUSY) && !wd_expire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - randomized self-checking bench for fft_sequencer with a frame-level reference model
module tb_fft_sequencer;

    localparam int N        = 64;
    localparam int W        = 16;
    localparam int TIMEOUT  = 1023;
    localparam int CORE_LAT = 200;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [W-1:0]        in_re = '0;
    logic [W-1:0]        in_im = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [W-1:0]        out_re;
    logic [W-1:0]        out_im;
    logic [5:0]          out_index;
    logic                out_last;
    logic                fft_start;
    logic                fft_done = 1'b0;
    logic [N-1:0][W-1:0] fft_in_re;
    logic [N-1:0][W-1:0] fft_in_im;
    logic [N-1:0][W-1:0] fft_out_re = '0;
    logic [N-1:0][W-1:0] fft_out_im = '0;
    logic                busy;
    logic [7:0]          frame_cnt;
    logic                err_timeout;

    fft_sequencer #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_index  (out_index),
        .out_last   (out_last),
        .fft_start  (fft_start),
        .fft_done   (fft_done),
        .fft_in_re  (fft_in_re),
        .fft_in_im  (fft_in_im),
        .fft_out_re (fft_out_re),
        .fft_out_im (fft_out_im),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] in_q[$];
    logic [31:0] part[$];
    logic [31:0] exp_q[$];
    int          cq[$];

    int  tick = 0;
    int  last_exit = -1000;
    int  full_tick = -1000;
    int  done_tick = -1000;
    int  last_start = -1000;
    int  out_pos = 0;
    int  model_fc = 0;
    int  n_start = 0;
    int  in_pct = 100;
    int  out_mode = 0;
    int  core_timer = 0;
    int  busy_run = 0;
    int  wd_busy = -1;
    bit  stop30 = 0;
    bit  hit30 = 0;
    bit  stray = 0;
    bit  core_hang = 0;
    bit  core_pending = 0;
    bit  stalled_prev = 0;
    bit  prev_start = 0;
    bit  err_seen = 0;
    logic [39:0]         prev_vec = '0;
    logic [N-1:0][W-1:0] lat_re;
    logic [N-1:0][W-1:0] lat_im;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in for the FFT core: any bin-dependent transform exposes ordering and buffering faults.
    function automatic logic [31:0] core_fn(input logic [15:0] re, input logic [15:0] im, input int k);
        logic [15:0] r;
        logic [15:0] i;
        r = re + 16'(k * 7);
        i = (im ^ 16'h00a5) - 16'(k);
        return {r, i};
    endfunction

    task automatic tick_once();
        logic [31:0] e;
        logic [31:0] ce;
        logic [39:0] vec;
        int          a;
        @(posedge clk);
        #1;
        tick++;

        fft_done = 1'b0;
        if (fft_start) begin
            n_start++;
            last_start = tick;
            chk("start_single", prev_start, 0);
            if (cq.size() == 0) begin
                chk("start_without_frame", fft_start, 0);
            end else begin
                a = cq.pop_front();
                chk("start_latency", tick, ((a > last_exit) ? a : last_exit) + 2);
            end
            for (int k = 0; k < N; k++) begin
                {lat_re[k], lat_im[k]} = core_fn(fft_in_re[k], fft_in_im[k], k);
            end
            core_pending = 1;
            core_timer   = CORE_LAT;
        end else if (core_pending && !core_hang) begin
            if (core_timer <= 1) begin
                fft_out_re   = lat_re;
                fft_out_im   = lat_im;
                fft_done     = 1'b1;
                core_pending = 0;
                done_tick    = tick;
            end else begin
                core_timer--;
            end
        end
        if (stray) fft_done = 1'b1;
        prev_start = fft_start;

        if (err_timeout) begin
            err_seen     = 1;
            wd_busy      = busy_run;
            last_exit    = tick - 1;
            core_pending = 0;
            for (int k = 0; k < N; k++) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        if (busy && !fft_start && !out_valid) busy_run++;
        else busy_run = 0;

        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (tick % 2 == 0);
            default: out_ready = 1'($urandom_range(1, 0));
        endcase
        if (stop30 && out_valid && out_index == 6'd30) begin
            out_ready = 1'b0;
            hit30     = 1;
        end

        vec = {out_valid, out_re, out_im, out_index, out_last};
        if (tick == done_tick + 1) chk("done_to_valid", out_valid, 1);
        if (stalled_prev) chk("stall_hold", vec, prev_vec);
        if (!out_valid) chk("last_gated", out_last, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", out_valid, 0);
            end else begin
                e  = exp_q.pop_front();
                ce = core_fn(e[31:16], e[15:0], out_pos);
                chk("out_data", {out_re, out_im, out_index, out_last},
                    {ce, 6'(out_pos), 1'(out_pos == N - 1)});
            end
            if (out_pos == N - 1) begin
                chk("frame_cnt_at_exit", frame_cnt, 8'(model_fc));
                model_fc++;
                last_exit = tick;
                out_pos   = 0;
            end else begin
                out_pos++;
            end
        end
        stalled_prev = out_valid && !out_ready;
        prev_vec     = vec;

        if (tick == full_tick + 1) chk("ready_drop", in_ready, 0);
        if (in_q.size() > 0 && $urandom_range(99, 0) < in_pct) begin
            in_valid       = 1'b1;
            {in_re, in_im} = in_q[0];
        end else begin
            in_valid = 1'b0;
            in_re    = 16'($urandom);
            in_im    = 16'($urandom);
        end
        if (in_valid && in_ready) begin
            part.push_back(in_q.pop_front());
            if (part.size() == N) begin
                foreach (part[i]) exp_q.push_back(part[i]);
                part.delete();
                cq.push_back(tick);
                full_tick = tick;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_buf_re", fft_in_re == '0, 1);
        chk("rst_buf_im", fft_in_im == '0, 1);
        in_valid = 1'b0;
        fft_done = 1'b0;
        stray = 0;
        core_hang = 0;
        stop30 = 0;
        in_q.delete();
        part.delete();
        exp_q.delete();
        cq.delete();
        out_pos = 0;
        model_fc = 0;
        last_exit = -1000;
        full_tick = -1000;
        done_tick = -1000;
        core_pending = 0;
        stalled_prev = 0;
        prev_start = 0;
        busy_run = 0;
        err_seen = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic push_random_frame();
        for (int k = 0; k < N; k++) in_q.push_back($urandom);
    endtask

    task automatic run_frames(input int target, input int max_ticks, input string tag);
        int n;
        n = 0;
        while (model_fc < target && n < max_ticks) begin
            tick_once();
            n++;
        end
        chk(tag, model_fc, target);
        tick_once();
    endtask

    initial begin
        int exit_a;
        int n;
        #2;
        do_reset();

        // Reset while draining bin 30, with part of the next frame already buffered.
        for (int k = 0; k < N + 10; k++) in_q.push_back($urandom);
        in_pct = 100;
        out_mode = 0;
        stop30 = 1;
        hit30 = 0;
        for (int i = 0; i < 2000 && !hit30; i++) tick_once();
        chk("reach_idx30", hit30, 1);
        do_reset();

        // re=k, im=0, always ready; also proves the write pointer restarted at 0.
        n_start = 0;
        for (int k = 0; k < N; k++) in_q.push_back({16'(k), 16'h0000});
        run_frames(1, 1000, "frame1_done");
        chk("frame1_starts", n_start, 1);
        chk("frame1_cnt", frame_cnt, 1);

        out_mode = 1;
        push_random_frame();
        run_frames(2, 1500, "stall_frame_done");
        chk("stall_frame_cnt", frame_cnt, 2);

        // Second frame arrives only once the first is draining.
        push_random_frame();
        n = 0;
        while (!out_valid && n < 1000) begin
            tick_once();
            n++;
        end
        chk("b2b_drain_seen", out_valid, 1);
        push_random_frame();
        run_frames(3, 1000, "b2b_first_done");
        exit_a = last_exit;
        run_frames(4, 1000, "b2b_second_done");
        chk("b2b_start", last_start, exit_a + 2);
        chk("b2b_cnt", frame_cnt, 4);

        out_mode = 2;
        in_pct = 30 + int'($urandom_range(70, 0));
        for (int f = 0; f < 4; f++) push_random_frame();
        run_frames(8, 8000, "random_frames_done");
        chk("random_cnt", frame_cnt, 8);

        out_mode = 0;
        stray = 1;
        tick_once();
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick_once();
            chk("stray_idle", {busy, out_valid}, 0);
        end
        chk("stray_cnt", frame_cnt, 8);

        do_reset();
        in_pct = 100;
        core_hang = 1;
        push_random_frame();
`ifdef FFT_SEQ_WATCHDOG_EN
        for (int i = 0; i < 3000 && !err_seen; i++) tick_once();
        chk("wd_fired", err_seen, 1);
        chk("wd_busy_cycles", wd_busy, TIMEOUT);
        chk("wd_idle", busy, 0);
        tick_once();
        chk("wd_pulse_once", err_timeout, 0);
        chk("wd_frame_cnt", frame_cnt, 0);
        core_hang = 0;
        push_random_frame();
        run_frames(1, 1000, "wd_recover_done");
        chk("wd_recover_cnt", frame_cnt, 1);
`else
        for (int i = 0; i < 1200; i++) tick_once();
        chk("hang_busy", busy, 1);
        chk("hang_no_err", err_seen, 0);
        core_hang = 0;
        run_frames(1, 1000, "hang_release_done");
        chk("hang_release_cnt", frame_cnt, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
